// File: rtl/redun_sq_collect.sv
// redun_sq_collect
// Collects results from the redundant-form Montgomery squaring loop. It counts
// completed squarings up to a programmed target and snapshots the redundant
// result of the target iteration. It then resolves the snapshot to canonical
// binary one word per cycle. The result is held for the consumer with a
// valid/ready handshake. No modular reduction is performed.
module redun_sq_collect #(
    parameter int NUM_WRDS  = 64,
    parameter int WRD_BITS  = 16,
    parameter int ITER_BITS = 64
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_start,
    input  logic [ITER_BITS-1:0]         i_iter,
    input  logic [WRD_BITS:0]            i_mul [NUM_WRDS],
    input  logic                         i_mul_val,
    output logic                         o_busy,
    output logic [ITER_BITS-1:0]         o_cnt,
    output logic [NUM_WRDS*WRD_BITS+1:0] o_dat,
    output logic                         o_val,
    input  logic                         i_rdy
);

    localparam int IDX_BITS = (NUM_WRDS > 1) ? $clog2(NUM_WRDS) : 1;
    localparam int DAT_BITS = NUM_WRDS * WRD_BITS + 2;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        RESOLVE,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [ITER_BITS-1:0]   target;
    logic [ITER_BITS-1:0]   cnt_inc;
    logic [WRD_BITS:0]      snap [NUM_WRDS];
    logic [1:0]             carry;
    logic [IDX_BITS-1:0]    idx;
    logic [WRD_BITS+1:0]    sum;
    logic                   hit;
    logic                   last_word;

    // A pulse that brings the count to the target is the one whose words are kept.
    // The carry is at most 2 because a word is at most 2^(W+1)-1 and the previous carry is at most 2.
    assign cnt_inc   = o_cnt + {{(ITER_BITS-1){1'b0}}, 1'b1};
    assign hit       = i_mul_val && (cnt_inc == target);
    assign last_word = (idx == IDX_BITS'(NUM_WRDS - 1));
    assign sum       = {1'b0, snap[idx]} + {{WRD_BITS{1'b0}}, carry};
    assign o_busy    = (state == COUNT) || (state == RESOLVE);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start)   state_next = COUNT;
            COUNT:   if (hit)       state_next = RESOLVE;
            RESOLVE: if (last_word) state_next = DONE;
            DONE:    if (i_rdy)     state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Datapath: target/count, snapshot capture, word-serial carry resolution and handshake
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            target <= '0;
            o_cnt  <= '0;
            carry  <= '0;
            idx    <= '0;
            o_dat  <= '0;
            o_val  <= 1'b0;
            for (int i = 0; i < NUM_WRDS; i++) begin
                snap[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        target <= (i_iter == '0) ? {{(ITER_BITS-1){1'b0}}, 1'b1} : i_iter;
                        o_cnt  <= '0;
                    end
                end
                COUNT: begin
                    if (i_mul_val) begin
                        o_cnt <= cnt_inc;
                    end
                    if (hit) begin
                        for (int i = 0; i < NUM_WRDS; i++) begin
                            snap[i] <= i_mul[i];
                        end
                        idx   <= '0;
                        carry <= '0;
                    end
                end
                RESOLVE: begin
                    o_dat[int'(idx)*WRD_BITS +: WRD_BITS] <= sum[WRD_BITS-1:0];
                    carry <= sum[WRD_BITS+1:WRD_BITS];
                    idx   <= idx + 1'b1;
                    if (last_word) begin
                        o_dat[DAT_BITS-1 -: 2] <= sum[WRD_BITS+1:WRD_BITS];
                        o_val                  <= 1'b1;
                    end
                end
                DONE: begin
                    if (i_rdy) begin
                        o_val <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_redun_sq_collect.sv
// tb_redun_sq_collect
// Directed bench for redun_sq_collect with NUM_WRDS=4 and WRD_BITS=16.
module tb_redun_sq_collect;

    localparam int NW = 4;
    localparam int WB = 16;
    localparam int IB = 64;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [IB-1:0]     iter;
    logic [WB:0]       mul [NW];
    logic              mul_val;
    logic              busy;
    logic [IB-1:0]     cnt;
    logic [NW*WB+1:0]  dat;
    logic              val;
    logic              rdy;

    int total;
    int bad;

    redun_sq_collect #(.NUM_WRDS(NW), .WRD_BITS(WB), .ITER_BITS(IB)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (start),
        .i_iter    (iter),
        .i_mul     (mul),
        .i_mul_val (mul_val),
        .o_busy    (busy),
        .o_cnt     (cnt),
        .o_dat     (dat),
        .o_val     (val),
        .i_rdy     (rdy)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Arm the collector with an iteration target
    task automatic applyStimulus(input logic [IB-1:0] n);
        iter  = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // One i_mul_val pulse carrying four words
    task automatic pulse(input logic [WB:0] w0, input logic [WB:0] w1,
                         input logic [WB:0] w2, input logic [WB:0] w3);
        mul[0]  = w0;
        mul[1]  = w1;
        mul[2]  = w2;
        mul[3]  = w3;
        mul_val = 1'b1;
        tick();
        mul_val = 1'b0;
    endtask

    // Wait for o_val with a cycle budget
    task automatic waitVal(input string tag, input int budget);
        int n;
        n = 0;
        while (!val && n < budget) begin
            tick();
            n++;
        end
        checkOutput(tag, {127'b0, val}, 128'd1);
    endtask

    // Accept the held result
    task automatic accept();
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        iter    = '0;
        mul_val = 1'b0;
        rdy     = 1'b0;
        for (int i = 0; i < NW; i++) mul[i] = '0;
        #23;
        checkOutput("rst_busy", {127'b0, busy}, 128'd0);
        checkOutput("rst_cnt",  {64'b0, cnt},   128'd0);
        checkOutput("rst_dat",  {62'b0, dat},   128'd0);
        checkOutput("rst_val",  {127'b0, val},  128'd0);
        rst_n = 1'b1;
        tick();

        // 1: three pulses, carries ripple across words, exact latency
        applyStimulus(64'd3);
        checkOutput("t1_busy", {127'b0, busy}, 128'd1);
        pulse(17'h0AAAA, 17'h1, 17'h2, 17'h3);
        pulse(17'h05555, 17'h4, 17'h5, 17'h6);
        pulse(17'h1FFFF, 17'h1FFFF, 17'h0, 17'h0);
        checkOutput("t1_cnt", {64'b0, cnt}, 128'd3);
        checkOutput("t1_val_early0", {127'b0, val}, 128'd0);
        tick(); tick(); tick();
        checkOutput("t1_val_early3", {127'b0, val}, 128'd0);
        tick();
        checkOutput("t1_val_on_time", {127'b0, val}, 128'd1);
        checkOutput("t1_dat", {62'b0, dat}, {62'b0, 66'h0_0000_0002_0000_FFFF});
        checkOutput("t1_busy_done", {127'b0, busy}, 128'd0);
        accept();
        checkOutput("t1_val_acc", {127'b0, val}, 128'd0);

        // 2: all words at max, carry reaches the top two bits
        applyStimulus(64'd1);
        pulse(17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF);
        waitVal("t2_val", 10);
        checkOutput("t2_dat", {62'b0, dat}, {62'b0, 66'h2_0001_0001_0000_FFFF});
        checkOutput("t2_cnt", {64'b0, cnt}, 128'd1);

        // 4: hold off acceptance while toggling start and mul_val
        for (int i = 0; i < 10; i++) begin
            start   = i[0];
            mul_val = ~i[0];
            mul[0]  = 17'(i);
            tick();
        end
        start   = 1'b0;
        mul_val = 1'b0;
        checkOutput("t4_dat", {62'b0, dat}, {62'b0, 66'h2_0001_0001_0000_FFFF});
        checkOutput("t4_val", {127'b0, val}, 128'd1);
        checkOutput("t4_cnt", {64'b0, cnt}, 128'd1);
        accept();
        checkOutput("t4_val_acc", {127'b0, val}, 128'd0);
        checkOutput("t4_busy_idle", {127'b0, busy}, 128'd0);

        // 3: zero target behaves as one
        applyStimulus(64'd0);
        checkOutput("t3_busy", {127'b0, busy}, 128'd1);
        pulse(17'h5, 17'h6, 17'h7, 17'h8);
        checkOutput("t3_cnt", {64'b0, cnt}, 128'd1);
        waitVal("t3_val", 10);
        checkOutput("t3_dat", {62'b0, dat}, {62'b0, 66'h0_0008_0007_0006_0005});
        accept();

        // 5: asynchronous reset mid-count, then rearm
        applyStimulus(64'd5);
        pulse(17'h9, 17'h9, 17'h9, 17'h9);
        pulse(17'h9, 17'h9, 17'h9, 17'h9);
        checkOutput("t5_cnt_pre", {64'b0, cnt}, 128'd2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_busy", {127'b0, busy}, 128'd0);
        checkOutput("t5_rst_cnt",  {64'b0, cnt},   128'd0);
        checkOutput("t5_rst_dat",  {62'b0, dat},   128'd0);
        checkOutput("t5_rst_val",  {127'b0, val},  128'd0);
        tick();
        rst_n = 1'b1;
        tick();
        applyStimulus(64'd2);
        pulse(17'h1, 17'h2, 17'h3, 17'h4);
        pulse(17'h1, 17'h2, 17'h3, 17'h4);
        waitVal("t5_val", 10);
        checkOutput("t5_dat", {62'b0, dat}, {62'b0, 66'h0_0004_0003_0002_0001});
        checkOutput("t5_cnt", {64'b0, cnt}, 128'd2);
        accept();

        // 6: back-to-back pulses, only the fourth is captured
        applyStimulus(64'd4);
        mul_val = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            mul[0] = 17'(n);
            mul[1] = 17'(n + 'h100);
            mul[2] = 17'(n + 'h200);
            mul[3] = 17'(n + 'h300);
            tick();
        end
        mul_val = 1'b0;
        checkOutput("t6_cnt_sat", {64'b0, cnt}, 128'd4);
        waitVal("t6_val", 10);
        checkOutput("t6_dat", {62'b0, dat}, {62'b0, 66'h0_0304_0204_0104_0004});
        accept();
        checkOutput("t6_val_acc", {127'b0, val}, 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/redun_sq_collect.md
Name: redun_sq_collect

Overview:
- Sits directly downstream of the redundant-form Montgomery squaring loop and consumes its per-iteration result words and valid pulse.
- Counts completed squarings against a programmed iteration target and snapshots the redundant result of the target iteration.
- Resolves the snapshot to canonical binary by word-serial carry propagation, then holds it with a valid/ready handshake for the host or readback logic.
- The output is carry-resolved only; no modular reduction against P is performed.

Parameters:
NUM_WRDS, 64, number of redundant words in the squarer result.
WRD_BITS, 16, canonical bits per word; each redundant word is WRD_BITS+1 bits.
ITER_BITS, 64, width of the iteration target and counter.

Ports:
i_clk  input  1  clock.
i_rst_n  input  1  reset, asynchronous, active-low.
i_start  input  1  pulse; arms the collector with i_iter. Honoured only in IDLE.
i_iter  input  ITER_BITS  number of squarings to wait for; sampled with i_start.
i_mul  input  [WRD_BITS:0] x NUM_WRDS (unpacked)  redundant result words from the squarer; word 0 is least significant.
i_mul_val  input  1  one-cycle pulse marking i_mul valid.
o_busy  output  1  high in COUNT or RESOLVE.
o_cnt  output  ITER_BITS  number of squarings counted since arm.
o_dat  output  NUM_WRDS*WRD_BITS+2  canonical resolved value.
o_val  output  1  o_dat valid; held until accepted.
i_rdy  input  1  consumer accepts o_dat when o_val && i_rdy.

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE, o_busy=0, o_cnt=0, o_dat=0, o_val=0, snapshot and carry registers cleared. Reset asserted mid-operation aborts immediately; the next i_start rearms normally.
- States: IDLE, COUNT, RESOLVE, DONE.
- IDLE:
  - i_start=1: latch target=max(i_iter,1) (i_iter=0 is treated as 1), set o_cnt=0, go COUNT.
  - i_mul_val is ignored in IDLE.
- COUNT:
  - Each i_mul_val pulse increments o_cnt.
  - When the pulse brings o_cnt to the target, capture all NUM_WRDS words of i_mul that same cycle, set word index k=0 and carry=0, go RESOLVE.
  - i_start in COUNT is ignored.
  - Pulses may be back-to-back; there is no minimum spacing.
- RESOLVE (exactly NUM_WRDS cycles):
  - Cycle k: sum = snap[k] + carry, a (WRD_BITS+2)-bit sum.
  - o_dat[k*WRD_BITS +: WRD_BITS] <= sum[WRD_BITS-1:0]; carry <= sum >> WRD_BITS. Carry is 2 bits, maximum value 2.
  - After k=NUM_WRDS-1: o_dat top 2 bits <= final carry, o_val <= 1, go DONE.
  - i_mul_val and i_start are ignored.
- DONE:
  - o_val held high and o_dat stable until i_rdy=1; then o_val <= 0 and go IDLE on the next edge.
  - i_start in the same cycle as acceptance is ignored. A new arm requires IDLE.
  - i_mul_val is ignored.
- Latency: the capturing i_mul_val edge, plus NUM_WRDS cycles of RESOLVE, gives o_val high on cycle NUM_WRDS+1 after capture.
- o_busy=1 exactly while in COUNT or RESOLVE.
- o_cnt saturates at the target and holds its value through RESOLVE and DONE.
- o_dat is written only during RESOLVE; it keeps its last value in IDLE and COUNT.

Test Plan (NUM_WRDS=4, WRD_BITS=16, 66-bit o_dat):
1. Reset then i_start with i_iter=3; drive 3 i_mul_val pulses; 3rd pulse carries {w0=0x1FFFF, w1=0x1FFFF, w2=0, w3=0} -> o_cnt=3; o_val rises 5 cycles after the 3rd pulse; o_dat=0x0_0000_0002_0000_FFFF.
2. Arm with i_iter=1; single pulse with all words 0x1FFFF -> o_dat=0x2_0001_0001_0000_FFFF (bit 65 set).
3. Arm with i_iter=0 -> behaves as i_iter=1: first pulse is captured.
4. Hold i_rdy=0 for 10 cycles after o_val; toggle i_mul_val and i_start meanwhile -> o_dat unchanged, o_val stays 1, o_cnt unchanged. Raise i_rdy -> o_val=0 next cycle, state IDLE.
5. Arm with i_iter=5; drop i_rst_n asynchronously after 2 pulses -> all outputs 0 immediately. Rearm with i_iter=2; 2 pulses of words {1,2,3,4} -> o_dat=0x0_0004_0003_0002_0001.
6. Back-to-back i_mul_val every cycle with i_iter=4; words change each pulse -> the 4th pulse's words are captured, not the 3rd's or 5th's.
